// File: rtl/seg7_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_if
// Bundles the display driver's data-side signals.
//   scan_clk    : divided scan clock, treated as plain data by the driver
//   data_in     : eight hex nibbles, nibble i shown on digit i
//   dp_in       : decimal point per digit, 1 = lit
//   lzb_en      : leading-zero blanking enable
//   an          : digit anodes, active-low
//   seg         : {dp,g,f,e,d,c,b,a}, active-low
//   frame_start : one-cycle pulse when digit 0 becomes active
// master = data source / board side, slave = seg7_scan.
// ---------------------------------------------------------------------------
interface seg7_scan_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NDIG   = 8;

  logic              scan_clk;
  logic [DATA_W-1:0] data_in;
  logic [NDIG-1:0]   dp_in;
  logic              lzb_en;
  logic [NDIG-1:0]   an;
  logic [7:0]        seg;
  logic              frame_start;

  modport master (
    output scan_clk, data_in, dp_in, lzb_en,
    input  an, seg, frame_start
  );

  modport slave (
    input  scan_clk, data_in, dp_in, lzb_en,
    output an, seg, frame_start
  );
endinterface

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
// Multiplexed seven-segment driver scanning DIGITS hex digits. The divided
// scan clock is synchronised into the clk domain and its rising edge becomes
// a one-cycle tick that advances the digit index. Display data is latched
// once per frame, on the tick that wraps the index back to digit 0.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   disp   : seg7_scan_if.slave (scan_clk, data_in, dp_in, lzb_en in;
//            an, seg, frame_start out, all registered)
// ---------------------------------------------------------------------------
module seg7_scan #(
  parameter int unsigned DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  disp
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NDIG   = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] p;
    p = 7'h7F;
    case (nib)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // State
  logic              s1_q, s2_q, s3_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_data_q, shadow_data_d;
  logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic              shadow_lzb_q, shadow_lzb_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_start_q, frame_start_d;

  // Decode helpers
  logic              tick_c;
  logic              wrap_c;
  logic [3:0]        sel_nib_c;
  logic [NDIG-1:0]   nib_nz_c;
  logic              upper_nz_c;
  logic              blank_c;

  // Three-flop synchroniser; the third flop only serves edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= disp.scan_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Index advance and frame latch.
  always_comb begin
    tick_c        = s2_q & ~s3_q;
    // >= keeps the index legal even if it were ever disturbed.
    wrap_c        = (idx_q >= LAST_IDX);
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_lzb_d  = shadow_lzb_q;
    if (tick_c) begin
      if (wrap_c) begin
        idx_d         = '0;
        shadow_data_d = disp.data_in;
        shadow_dp_d   = disp.dp_in;
        shadow_lzb_d  = disp.lzb_en;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Per-digit non-zero flags; digits beyond DIGITS never count.
  for (genvar g = 0; g < NDIG; g++) begin : g_nz
    assign nib_nz_c[g] = (g < DIGITS) && (shadow_data_d[4*g +: 4] != 4'h0);
  end

  // Output patterns are computed from the post-tick index and shadow.
  always_comb begin
    sel_nib_c     = shadow_data_d[{idx_d, 2'b00} +: 4];
    upper_nz_c    = |(nib_nz_c >> idx_d);
    blank_c       = shadow_lzb_d && (idx_d != '0) && !upper_nz_c;
    an_d          = an_q;
    seg_d         = seg_q;
    frame_start_d = tick_c & wrap_c;
    if (tick_c) begin
      an_d        = '1;
      an_d[idx_d] = 1'b0;
      seg_d       = {~shadow_dp_d[idx_d], blank_c ? 7'h7F : hex_decode(sel_nib_c)};
    end
  end

  // Index, shadow and output registers; reset darkens the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_lzb_q  <= 1'b0;
      an_q          <= '1;
      seg_q         <= '1;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_lzb_q  <= shadow_lzb_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign disp.an          = an_q;
  assign disp.seg         = seg_q;
  assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
// Drives an 8-digit and a 4-digit instance with the same inputs. Stimulus
// pushes hand-computed {an,seg,frame_start} expectations per scan tick; two
// monitors pop and compare whenever a DUT's anode pattern changes.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_if bus8 ();
  seg7_scan_if bus4 ();

  seg7_scan #(.DIGITS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .disp(bus8));
  seg7_scan #(.DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .disp(bus4));

  exp_t q8[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   scb_en = 1'b1;
  int   t4 = 0;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got an=%h seg=%h fs=%b, want an=%h seg=%h fs=%b",
               name, act[16:9], act[8:1], act[0], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic set_in(input logic [31:0] d, input logic [7:0] dp, input logic lzb);
    bus8.data_in = d;  bus8.dp_in = dp;  bus8.lzb_en = lzb;
    bus4.data_in = d;  bus4.dp_in = dp;  bus4.lzb_en = lzb;
  endtask

  task automatic set_scan(input logic v);
    bus8.scan_clk = v;
    bus4.scan_clk = v;
  endtask

  // One scan_clk period of 8 clk; queue what both DUTs must show after it.
  task automatic tk(input logic [7:0] an, input logic [7:0] seg, input logic fs);
    exp_t e4;
    q8.push_back('{an: an, seg: seg, fs: fs});
    t4 = (t4 == 3) ? 0 : t4 + 1;
    e4.an  = 8'hFF ^ (8'h01 << t4);
    e4.seg = 8'h00;
    e4.fs  = (t4 == 0);
    q4.push_back(e4);
    @(negedge clk) set_scan(1'b1);
    repeat (4) @(negedge clk);
    set_scan(1'b0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor for the 8-digit instance.
  initial begin
    logic [7:0] prev;
    exp_t e;
    prev = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 8'hFF;
      end else if (bus8.an !== prev) begin
        prev = bus8.an;
        if (!scb_en) begin
          chk("legal_an8", {bus8.an, 8'h00, 1'b0},
              {($countones(bus8.an) == 7) ? bus8.an : 8'h00, 8'h00, 1'b0});
        end else if (q8.size() == 0) begin
          chk("unexpected8", {bus8.an, bus8.seg, bus8.frame_start}, 17'h0);
        end else begin
          e = q8.pop_front();
          chk("scan8", {bus8.an, bus8.seg, bus8.frame_start}, {e.an, e.seg, e.fs});
        end
      end else if (bus8.frame_start) begin
        chk("spurious_fs8", {bus8.an, bus8.seg, bus8.frame_start}, {bus8.an, bus8.seg, 1'b0});
      end
    end
  end

  // Monitor for the 4-digit instance; checks anodes and frame_start.
  initial begin
    logic [7:0] prev;
    exp_t e;
    prev = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 8'hFF;
      end else if (bus4.an !== prev) begin
        prev = bus4.an;
        if (!scb_en) begin
          chk("legal_an4", {bus4.an, 8'h00, 1'b0},
              {(bus4.an[7:4] == 4'hF && $countones(bus4.an[3:0]) == 3) ? bus4.an : 8'h00,
               8'h00, 1'b0});
        end else if (q4.size() == 0) begin
          chk("unexpected4", {bus4.an, 8'h00, bus4.frame_start}, 17'h0);
        end else begin
          e = q4.pop_front();
          chk("scan4", {bus4.an, 8'h00, bus4.frame_start}, {e.an, 8'h00, e.fs});
        end
      end else if (bus4.frame_start) begin
        chk("spurious_fs4", {bus4.an, 8'h00, bus4.frame_start}, {bus4.an, 8'h00, 1'b0});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_scan(1'b0);
    set_in(32'h0, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Static scan clock: display stays dark.
    repeat (100) begin
      @(negedge clk);
      chk("dark8", {bus8.an, bus8.seg, bus8.frame_start}, {8'hFF, 8'hFF, 1'b0});
      chk("dark4", {bus4.an, bus4.seg, bus4.frame_start}, {8'hFF, 8'hFF, 1'b0});
    end

    // First frame after reset shows the zeroed shadow; wrap latches new data.
    set_in(32'h76543210, 8'h00, 1'b0);
    tk(8'hFD, 8'hC0, 0); tk(8'hFB, 8'hC0, 0); tk(8'hF7, 8'hC0, 0); tk(8'hEF, 8'hC0, 0);
    tk(8'hDF, 8'hC0, 0); tk(8'hBF, 8'hC0, 0); tk(8'h7F, 8'hC0, 0); tk(8'hFE, 8'hC0, 1);
    tk(8'hFD, 8'hF9, 0); tk(8'hFB, 8'hA4, 0); tk(8'hF7, 8'hB0, 0); tk(8'hEF, 8'h99, 0);
    tk(8'hDF, 8'h92, 0); tk(8'hBF, 8'h82, 0); tk(8'h7F, 8'hF8, 0); tk(8'hFE, 8'hC0, 1);
    tk(8'hFD, 8'hF9, 0); tk(8'hFB, 8'hA4, 0); tk(8'hF7, 8'hB0, 0);

    // Mid-frame change is invisible until the wrap.
    set_in(32'hFFFFFFFF, 8'h00, 1'b0);
    tk(8'hEF, 8'h99, 0); tk(8'hDF, 8'h92, 0); tk(8'hBF, 8'h82, 0); tk(8'h7F, 8'hF8, 0);
    tk(8'hFE, 8'h8E, 1);
    tk(8'hFD, 8'h8E, 0); tk(8'hFB, 8'h8E, 0); tk(8'hF7, 8'h8E, 0); tk(8'hEF, 8'h8E, 0);
    tk(8'hDF, 8'h8E, 0); tk(8'hBF, 8'h8E, 0); tk(8'h7F, 8'h8E, 0);

    // Leading-zero blanking with a lit decimal point on digit 2.
    set_in(32'h000000A0, 8'h04, 1'b1);
    tk(8'hFE, 8'hC0, 1);
    tk(8'hFD, 8'h88, 0); tk(8'hFB, 8'h7F, 0); tk(8'hF7, 8'hFF, 0); tk(8'hEF, 8'hFF, 0);
    tk(8'hDF, 8'hFF, 0); tk(8'hBF, 8'hFF, 0); tk(8'h7F, 8'hFF, 0); tk(8'hFE, 8'hC0, 1);
    tk(8'hFD, 8'h88, 0); tk(8'hFB, 8'h7F, 0);

    // One-cycle reset mid-frame darkens immediately.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async8", {bus8.an, bus8.seg, bus8.frame_start}, {8'hFF, 8'hFF, 1'b0});
    chk("rst_async4", {bus4.an, bus4.seg, bus4.frame_start}, {8'hFF, 8'hFF, 1'b0});
    t4 = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // After release the first tick selects digit 1 with the cleared shadow.
    tk(8'hFD, 8'hC0, 0); tk(8'hFB, 8'hC0, 0);

    // Narrow scan pulses: only legality of the anode pattern is checked.
    scb_en = 1'b0;
    repeat (20) begin
      @(negedge clk) set_scan(1'b1);
      @(negedge clk) set_scan(1'b0);
    end
    repeat (6) begin
      @(negedge clk) set_scan(1'b1);
      @(negedge clk) set_scan(1'b0);
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    chk("q8_drained", {8'(q8.size()), 9'h0}, 17'h0);
    chk("q4_drained", {8'(q4.size()), 9'h0}, 17'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
